// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b datapath types: machine word and memory-operation encodings.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LDR  = 3'd1,
        MEM_LDB  = 3'd2,
        MEM_STR  = 3'd3,
        MEM_STB  = 3'd4,
        MEM_LDI  = 3'd5,
        MEM_STI  = 3'd6
    } lc3b_mem_op;

    function automatic logic is_byte_op(input lc3b_mem_op op);
        return (op == MEM_LDB) || (op == MEM_STB);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: store replication and lane mask, load byte select with sign-extension.
module mem_byte_lane
    import lc3b_types::*;
(
    input  logic       i_byte,
    input  logic       i_addr_lsb,
    input  lc3b_word   i_wdata,
    input  lc3b_word   i_rdata,
    output lc3b_word   o_wdata,
    output logic [1:0] o_be,
    output lc3b_word   o_rdata
);

    logic [7:0] w_sel_byte;

    assign w_sel_byte = i_addr_lsb ? i_rdata[15:8] : i_rdata[7:0];

    // A byte store drives both lanes; the mask alone picks the one that lands.
    assign o_wdata = i_byte ? {i_wdata[7:0], i_wdata[7:0]} : i_wdata;
    assign o_be    = i_byte ? (i_addr_lsb ? 2'b10 : 2'b01) : 2'b11;
    assign o_rdata = i_byte ? {{8{w_sel_byte[7]}}, w_sel_byte} : i_rdata;

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b memory-stage controller: issues the data access, stalls upstream until done.
// MEM_INDIRECT_EN enables the two-phase LDI/STI path; otherwise those ops act as MEM_NONE.
module mem_access_unit
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [2:0]  mem_op_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_wdata,
    output logic        mem_stall,
    output logic [15:0] rdata_out,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
`ifdef MEM_INDIRECT_EN
        S_INDIRECT = 2'd2,
`endif
        S_DONE     = 2'd3
    } state_t;

    state_t     r_state;
    lc3b_mem_op r_op;
    lc3b_word   r_addr;
    lc3b_word   r_wdata;
    lc3b_word   r_rdata;
`ifdef MEM_INDIRECT_EN
    logic [15:1] r_ptr;
`endif

    lc3b_mem_op  w_op;
    logic        w_op_ok;
    logic        w_start;
    logic        w_in_indirect;
    logic        w_active;
    logic        w_access_rd;
    logic        w_access_wr;
    logic [15:1] w_base;
    lc3b_word    w_lane_wdata;
    logic [1:0]  w_lane_be;
    lc3b_word    w_lane_rdata;

    assign w_op = lc3b_mem_op'(mem_op_in);

    always_comb begin
        w_op_ok = 1'b0;
        case (w_op)
            MEM_LDR, MEM_LDB, MEM_STR, MEM_STB: w_op_ok = 1'b1;
`ifdef MEM_INDIRECT_EN
            MEM_LDI, MEM_STI:                   w_op_ok = 1'b1;
`endif
            default:                            w_op_ok = 1'b0;
        endcase
    end

    assign w_start = valid_in && w_op_ok;

`ifdef MEM_INDIRECT_EN
    assign w_in_indirect = (r_state == S_INDIRECT);
    assign w_base        = w_in_indirect ? r_ptr : r_addr[15:1];
`else
    assign w_in_indirect = 1'b0;
    assign w_base        = r_addr[15:1];
`endif

    assign w_active    = (r_state == S_ACCESS) || w_in_indirect;
    // STI fetches its pointer with a read; only the second phase writes.
    assign w_access_rd = (r_op == MEM_LDR) || (r_op == MEM_LDB) || (r_op == MEM_LDI) || (r_op == MEM_STI);
    assign w_access_wr = (r_op == MEM_STR) || (r_op == MEM_STB);

    mem_byte_lane u_lane (
        .i_byte     (is_byte_op(r_op)),
        .i_addr_lsb (r_addr[0]),
        .i_wdata    (r_wdata),
        .i_rdata    (dmem_rdata),
        .o_wdata    (w_lane_wdata),
        .o_be       (w_lane_be),
        .o_rdata    (w_lane_rdata)
    );

    assign dmem_read        = ((r_state == S_ACCESS) && w_access_rd) || (w_in_indirect && (r_op == MEM_LDI));
    assign dmem_write       = ((r_state == S_ACCESS) && w_access_wr) || (w_in_indirect && (r_op == MEM_STI));
    assign dmem_address     = {w_base, 1'b0};
    assign dmem_byte_enable = w_active ? w_lane_be : 2'b00;
    assign dmem_wdata       = w_lane_wdata;
    assign mem_stall        = w_active || ((r_state == S_IDLE) && w_start);
    assign done             = (r_state == S_DONE);
    assign rdata_out        = r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= MEM_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
`ifdef MEM_INDIRECT_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op    <= w_op;
                        r_addr  <= addr_in;
                        r_wdata <= wdata_in;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (dmem_resp) begin
                        r_state <= S_DONE;
                        if ((r_op == MEM_LDR) || (r_op == MEM_LDB))
                            r_rdata <= w_lane_rdata;
`ifdef MEM_INDIRECT_EN
                        if ((r_op == MEM_LDI) || (r_op == MEM_STI)) begin
                            r_ptr   <= dmem_rdata[15:1];
                            r_state <= S_INDIRECT;
                        end
`endif
                    end
                end
`ifdef MEM_INDIRECT_EN
                S_INDIRECT: begin
                    if (dmem_resp) begin
                        if (r_op == MEM_LDI)
                            r_rdata <= dmem_rdata;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random ops against a word-memory reference model.
module tb_mem_access_unit;

    localparam logic [2:0] OP_NONE = 3'd0, OP_LDR = 3'd1, OP_LDB = 3'd2, OP_STR = 3'd3,
                           OP_STB = 3'd4, OP_LDI = 3'd5, OP_STI = 3'd6;
`ifdef MEM_INDIRECT_EN
    localparam bit IND = 1'b1;
`else
    localparam bit IND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [2:0]  mem_op_in;
    logic [15:0] addr_in, wdata_in, dmem_rdata;
    logic        dmem_resp;
    logic [15:0] dmem_address, dmem_wdata, rdata_out;
    logic        dmem_read, dmem_write, mem_stall, done;
    logic [1:0]  dmem_byte_enable;

    int n_cmp = 0;
    int n_err = 0;
    int t_cyc, t_stalls, t_dones, t_lat;
    logic [15:0] mem [int unsigned];
    logic [15:0] exp_rdata;

    mem_access_unit dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .mem_op_in        (mem_op_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .mem_stall        (mem_stall),
        .rdata_out        (rdata_out),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_get(input logic [15:0] a);
        int unsigned k = int'(a) / 2;
        if (!mem.exists(k)) mem[k] = 16'($urandom);
        return mem[k];
    endfunction

    task automatic sample();
        t_cyc++;
        t_stalls += int'(mem_stall);
        if (done === 1'b1) begin
            t_dones++;
            if (t_lat == 0) t_lat = t_cyc;
        end
    endtask

    // One request phase: wt idle cycles, then a response carrying rsp.
    task automatic phase(input logic [15:0] ea, input logic rd, input logic wr, input logic [1:0] be,
                         input logic [15:0] wd, input logic [15:0] rsp, input int wt);
        for (int c = 0; c <= wt; c++) begin
            @(posedge clk); #1;
            dmem_resp  = (c == wt);
            dmem_rdata = (c == wt) ? rsp : 16'($urandom);
            @(negedge clk);
            chk("req_read", dmem_read, rd);
            chk("req_write", dmem_write, wr);
            chk("req_addr", dmem_address, ea);
            chk("req_be", dmem_byte_enable, be);
            chk("req_stall", mem_stall, 1'b1);
            chk("req_done", done, 1'b0);
            if (wr) chk("req_wdata", dmem_wdata, wd);
            sample();
        end
    endtask

    task automatic run_op(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] wd,
                          input int w0, input int w1);
        bit          is_ind, act, rd1;
        logic [1:0]  be1;
        logic [15:0] wa, wdat1, rsp, ptr, r2, w;
        int          s;
        t_cyc = 0; t_stalls = 0; t_dones = 0; t_lat = 0;
        is_ind = IND && (op == OP_LDI || op == OP_STI);
        act    = v && ((op inside {OP_LDR, OP_LDB, OP_STR, OP_STB}) || is_ind);
        @(posedge clk); #1;
        valid_in = v; mem_op_in = op; addr_in = a; wdata_in = wd;
        dmem_resp = 1'b0; dmem_rdata = 16'($urandom);
        @(negedge clk);
        chk("detect_stall", mem_stall, act);
        chk("detect_done", done, 1'b0);
        chk("detect_read", dmem_read, 1'b0);
        chk("detect_write", dmem_write, 1'b0);
        sample();
        if (!act) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_read", dmem_read, 1'b0);
            chk("idle_write", dmem_write, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_rdata", rdata_out, exp_rdata);
            return;
        end
        wa    = a & 16'hFFFE;
        rd1   = op inside {OP_LDR, OP_LDB, OP_LDI, OP_STI};
        be1   = (op == OP_LDB || op == OP_STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        wdat1 = (op == OP_STB) ? {wd[7:0], wd[7:0]} : wd;
        rsp   = rd1 ? mem_get(wa) : 16'($urandom);
        phase(wa, rd1, !rd1, be1, wdat1, rsp, w0);
        case (op)
            OP_LDR: exp_rdata = rsp;
            OP_LDB: begin
                s = a[0] ? int'(rsp) / 256 : int'(rsp) % 256;
                if (s > 127) s -= 256;
                exp_rdata = 16'(s);
            end
            OP_STR: mem[int'(wa) / 2] = wd;
            OP_STB: begin
                w = mem_get(wa);
                w = a[0] ? ((w & 16'h00FF) | 16'(int'(wd % 256) * 256)) : ((w & 16'hFF00) | (wd & 16'h00FF));
                mem[int'(wa) / 2] = w;
            end
            OP_LDI: begin
                ptr = rsp & 16'hFFFE;
                r2  = mem_get(ptr);
                phase(ptr, 1'b1, 1'b0, 2'b11, wd, r2, w1);
                exp_rdata = r2;
            end
            OP_STI: begin
                ptr = rsp & 16'hFFFE;
                phase(ptr, 1'b0, 1'b1, 2'b11, wd, 16'($urandom), w1);
                mem[int'(ptr) / 2] = wd;
            end
            default: ;
        endcase
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("done_stall", mem_stall, 1'b0);
        chk("done_read", dmem_read, 1'b0);
        chk("done_write", dmem_write, 1'b0);
        chk("done_be", dmem_byte_enable, 2'b00);
        chk("done_rdata", rdata_out, exp_rdata);
        sample();
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; mem_op_in = OP_NONE; addr_in = '0; wdata_in = '0;
        dmem_rdata = '0; dmem_resp = 1'b0; exp_rdata = '0;
        #3;
        chk("rst_read", dmem_read, 1'b0);
        chk("rst_write", dmem_write, 1'b0);
        chk("rst_be", dmem_byte_enable, 2'b00);
        chk("rst_addr", dmem_address, 16'h0000);
        chk("rst_wdata", dmem_wdata, 16'h0000);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_rdata", rdata_out, 16'h0000);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // LDB, high byte, response on the second request cycle
        mem[32'h3000 / 2] = 16'h80FF;
        run_op(1'b1, OP_LDB, 16'h3001, 16'h5555, 1, 0);
        chk("ldb_rdata", rdata_out, 16'hFF80);
        chk("ldb_stalls", 16'(t_stalls), 16'd3);
        chk("ldb_dones", 16'(t_dones), 16'd1);

        // STB, low lane, zero-wait
        run_op(1'b1, OP_STB, 16'h2000, 16'h12AB, 0, 0);
        chk("stb_latency", 16'(t_lat), 16'd3);
        chk("stb_rdata_hold", rdata_out, 16'hFF80);

        // LDI through pointer
        mem[32'h4000 / 2] = 16'h5000;
        mem[32'h5000 / 2] = 16'hBEEF;
        run_op(1'b1, OP_LDI, 16'h4000, 16'h0000, 0, 0);
        chk("ldi_latency", 16'(t_lat), IND ? 16'd4 : 16'd0);
        chk("ldi_stalls", 16'(t_stalls), IND ? 16'd3 : 16'd0);
        chk("ldi_rdata", rdata_out, IND ? 16'hBEEF : 16'hFF80);

        // STI through pointer
        mem[32'h7000 / 2] = 16'h6002;
        run_op(1'b1, OP_STI, 16'h7000, 16'h1234, 0, 0);
        chk("sti_dones", 16'(t_dones), IND ? 16'd1 : 16'd0);
        chk("sti_stalls", 16'(t_stalls), IND ? 16'd3 : 16'd0);

        // Back-to-back LDRs then a MEM_NONE
        mem[32'h1000 / 2] = 16'h1111;
        mem[32'h1002 / 2] = 16'h2222;
        run_op(1'b1, OP_LDR, 16'h1000, 16'h0000, 0, 0);
        chk("ldr1_dones", 16'(t_dones), 16'd1);
        run_op(1'b1, OP_LDR, 16'h1003, 16'h0000, 0, 0);
        chk("ldr2_dones", 16'(t_dones), 16'd1);
        run_op(1'b1, OP_NONE, 16'h1004, 16'h0000, 0, 0);
        chk("none_dones", 16'(t_dones), 16'd0);
        chk("ldr2_hold", rdata_out, 16'h2222);

        for (int i = 0; i < 80; i++) begin
            run_op(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 6)),
                   16'h1000 + 16'($urandom_range(0, 31)), 16'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of an access
        @(posedge clk); #1;
        valid_in = 1'b1; mem_op_in = OP_LDR; addr_in = 16'h1234; dmem_resp = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_read_pre", dmem_read, 1'b1);
        #1;
        reset = 1'b1; valid_in = 1'b0;
        #1;
        chk("mid_read_async", dmem_read, 1'b0);
        chk("mid_stall_async", mem_stall, 1'b0);
        chk("mid_rdata_async", rdata_out, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rdata = 16'h0000;
        @(negedge clk);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_stall", mem_stall, 1'b0);
        chk("post_rst_read", dmem_read, 1'b0);
        chk("post_rst_rdata", rdata_out, 16'h0000);
        run_op(1'b1, OP_LDR, 16'h1000, 16'h0000, 2, 0);
        chk("post_rst_ldr_dones", 16'(t_dones), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
